multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Main control unit of the multicycle CPU; sits directly upstream of the ALU control decoder and drives its 2-bit ALUOp plus every datapath mux and enable. A Moore state machine sequences each instruction through fetch/decode/execute/memory/writeback. It stalls on a memory-ready handshake, traps illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state may wait for MemReady before trapping (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Opcode  in  6  IR[31:26]; valid from DECODE onward
Zero  in  1  ALU zero flag, sampled in BRANCH
MemReady  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if branch taken
BranchNE  out  1  1 = taken when Zero==0 (BNE), 0 = taken when Zero==1 (BEQ)
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
MemtoReg  out  1  writeback source: 1=MDR, 0=ALUOut
RegDst  out  1  dest register: 1=rd, 0=rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=regA
ALUSrcB  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  out  2  to ALU control: 00 add, 01 immediate-class, 10 branch compare, 11 R-type funct-from-opcode
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
Halted  out  1  in HALT state
Trap  out  1  in TRAP state (sticky until reset)
Retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Opcode classes by Opcode[5:3]: 000 R-type, 001 I-type ALU, 010 LW, 011 SW, 100 branch (Opcode[0] selects BNE), 101 J, 111 HALT; 110 illegal.
- States: RST, FETCH, DECODE, MEM_ADDR, MEM_RD, LW_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT, TRAP.
- Rst_n low: state=RST immediately, Retired=0, wait counter=0; all outputs 0 in RST. RST->FETCH unconditionally next cycle.
- Outputs are pure functions of the state register (Moore); no output depends combinationally on inputs.
- FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. Holds until MemReady; the MemReady cycle also asserts IRWrite and PCWrite (only exception to Moore rule: gated by MemReady). ->DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch per class: LW/SW->MEM_ADDR, R->EXEC_R, I->EXEC_I, branch->BRANCH, J->JUMP, HALT->HALT, illegal->TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; ->MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead, IorD=1; wait for MemReady ->LW_WB. LW_WB: RegWrite, MemtoReg=1, RegDst=0.
- MEM_WR: MemWrite, IorD=1; MemReady ->FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=11; ->R_WB (RegWrite, RegDst=1, MemtoReg=0).
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=01; ->I_WB (RegWrite, RegDst=0, MemtoReg=0).
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCWriteCond, PCSource=01, BranchNE=Opcode[0] (latched in DECODE). JUMP: PCWrite, PCSource=10.
- Retired increments by 1 on the final cycle of each instruction (exit of LW_WB, MEM_WR with MemReady, R_WB, I_WB, BRANCH, JUMP) and on entry to HALT; never in TRAP.
- Wait counter: cleared on entering FETCH/MEM_RD/MEM_WR; increments each cycle MemReady=0 there; reaching MEM_TIMEOUT ->TRAP. MemReady on the same cycle the counter hits the limit wins (access completes).
- HALT, TRAP: absorbing; exit only by reset. Reset mid-access drops MemRead/MemWrite asynchronously.

Decomposition:
- Package: state enum, opcode-class constants, ALUOp encodings (shared with ALU control decoder), ALUSrcB/PCSource encodings.
- One sub-module natural: mem_wait_timer (counter, clear, limit compare, timeout flag).

Test Plan:
- Reset, MemReady tied 1, Opcode=000010 (R) -> FETCH,DECODE,EXEC_R(ALUOp=11),R_WB(RegWrite=1,RegDst=1), Retired=1 after 4 cycles past RST.
- LW Opcode=010000, MemReady low 3 cycles in MEM_RD -> MemRead/IorD=1 held 4 cycles, then LW_WB MemtoReg=1.
- BNE Opcode=100001, Zero=0 -> BRANCH: ALUOp=10, PCWriteCond=1, BranchNE=1, PCSource=01.
- MemReady stuck 0 in FETCH, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, Trap=1, Retired unchanged.
- Opcode=110000 -> DECODE->TRAP; Opcode=111000 -> HALT, Halted=1, Retired incremented, held 20 cycles.
- Rst_n pulsed low during MEM_WR -> MemWrite drops same cycle, Retired=0, restart via RST->FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle CPU main control unit.
// Holds the controller state encoding, the opcode-class codes taken from
// Opcode[5:3], and the ALUOp / ALUSrcB / PCSource encodings. The ALU control
// decoder imports the same ALUOp codes.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_LW_WB,
    ST_MEM_WR,
    ST_EXEC_R,
    ST_R_WB,
    ST_EXEC_I,
    ST_I_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT,
    ST_TRAP
  } state_e;

  // Instruction classes decoded from Opcode[5:3]
  localparam logic [2:0] CLS_RTYPE   = 3'b000;
  localparam logic [2:0] CLS_ITYPE   = 3'b001;
  localparam logic [2:0] CLS_LW      = 3'b010;
  localparam logic [2:0] CLS_SW      = 3'b011;
  localparam logic [2:0] CLS_BRANCH  = 3'b100;
  localparam logic [2:0] CLS_JUMP    = 3'b101;
  localparam logic [2:0] CLS_ILLEGAL = 3'b110;
  localparam logic [2:0] CLS_HALT    = 3'b111;

  // ALUOp codes seen by the ALU control decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_IMM    = 2'b01;
  localparam logic [1:0] ALUOP_BRANCH = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] ALUB_REGB     = 2'b00;
  localparam logic [1:0] ALUB_FOUR     = 2'b01;
  localparam logic [1:0] ALUB_IMM      = 2'b10;
  localparam logic [1:0] ALUB_IMM_SHL2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Wait counter width; covers timeout limits up to 255
  localparam int WAIT_W = 8;

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait timer for the main control unit.
// Counts the cycles a memory-access state has spent without MemReady and
// flags a timeout once the limit is reached while memory is still not ready.
// Ports:
//   Clk, Rst_n  - clock and asynchronous active-low reset
//   i_clear     - restart the count (controller is entering a new state)
//   i_waiting   - controller sits in a memory-access state
//   i_ready     - MemReady from memory
//   o_timeout   - limit reached and memory still not ready this cycle
module mem_wait_timer #(
  parameter int LIMIT = 15,
  parameter int W     = 8
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_clear,
  input  logic i_waiting,
  input  logic i_ready,
  output logic o_timeout
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] r_count;

  // Clear takes priority so the count always starts at zero in a new state;
  // only cycles spent waiting without MemReady are counted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_waiting && !i_ready) begin
      r_count <= r_count + W'(1);
    end
  end

  // A MemReady arriving on the limit cycle still completes the access
  assign o_timeout = i_waiting && !i_ready && (r_count == LIMIT_V);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle CPU.
// Moore FSM sequencing fetch/decode/execute/memory/writeback, driving all
// datapath muxes and enables plus the 2-bit ALUOp to the ALU control decoder.
// Stalls on MemReady, traps illegal opcodes and memory timeouts, and counts
// retired instructions.
// Ports:
//   Clk, Rst_n          - clock, asynchronous active-low reset
//   Opcode, Zero        - IR[31:26] and ALU zero flag
//   MemReady            - memory completes the current access this cycle
//   PCWrite..PCSource   - datapath controls
//   Halted, Trap        - terminal-state indicators
//   Retired             - retired-instruction count (wraps)
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             Halted,
  output logic             Trap,
  output logic [CNT_W-1:0] Retired
);

  state_e           r_state;
  state_e           w_nextState;
  logic             r_branchNe;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_waiting;
  logic             w_timeout;
  logic             w_timerClear;
  logic [2:0]       w_class;
  logic             w_unusedBits;

  assign w_class = Opcode[5:3];

  // Branch resolution (Zero combined with PCWriteCond/BranchNE) happens in
  // the datapath, and Opcode[2:1] carry no control meaning here.
  assign w_unusedBits = ^{Zero, Opcode[2:1]};

  // Any state change restarts the wait count, covering every entry into
  // FETCH, MEM_RD and MEM_WR.
  assign w_timerClear = (w_nextState != r_state);

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT),
    .W    (WAIT_W)
  ) u_memWaitTimer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .i_clear  (w_timerClear),
    .i_waiting(w_waiting),
    .i_ready  (MemReady),
    .o_timeout(w_timeout)
  );

  // State register, BNE/BEQ select captured while decoding, retire counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_RST;
      r_branchNe <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_DECODE) begin
        r_branchNe <= Opcode[0];
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign Retired = r_retired;

  // Next-state and Moore outputs. IRWrite/PCWrite in FETCH are the single
  // exception: they are qualified by MemReady so the IR loads only once.
  always_comb begin
    w_nextState = r_state;
    w_retire    = 1'b0;
    w_waiting   = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUB_REGB;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    Halted      = 1'b0;
    Trap        = 1'b0;
    case (r_state)
      ST_RST: w_nextState = ST_FETCH;
      ST_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = ALUB_FOUR;
        w_waiting = 1'b1;
        if (MemReady) begin
          IRWrite     = 1'b1;
          PCWrite     = 1'b1;
          w_nextState = ST_DECODE;
        end else if (w_timeout) begin
          w_nextState = ST_TRAP;
        end
      end
      ST_DECODE: begin
        ALUSrcB = ALUB_IMM_SHL2;
        case (w_class)
          CLS_RTYPE:   w_nextState = ST_EXEC_R;
          CLS_ITYPE:   w_nextState = ST_EXEC_I;
          CLS_LW:      w_nextState = ST_MEM_ADDR;
          CLS_SW:      w_nextState = ST_MEM_ADDR;
          CLS_BRANCH:  w_nextState = ST_BRANCH;
          CLS_JUMP:    w_nextState = ST_JUMP;
          CLS_ILLEGAL: w_nextState = ST_TRAP;
          CLS_HALT: begin
            w_nextState = ST_HALT;
            w_retire    = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = ALUB_IMM;
        w_nextState = (w_class == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        w_waiting = 1'b1;
        if (MemReady) begin
          w_nextState = ST_LW_WB;
        end else if (w_timeout) begin
          w_nextState = ST_TRAP;
        end
      end
      ST_LW_WB: begin
        RegWrite    = 1'b1;
        MemtoReg    = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_MEM_WR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        w_waiting = 1'b1;
        if (MemReady) begin
          w_retire    = 1'b1;
          w_nextState = ST_FETCH;
        end else if (w_timeout) begin
          w_nextState = ST_TRAP;
        end
      end
      ST_EXEC_R: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = ALUB_REGB;
        ALUOp       = ALUOP_RTYPE;
        w_nextState = ST_R_WB;
      end
      ST_R_WB: begin
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_EXEC_I: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = ALUB_IMM;
        ALUOp       = ALUOP_IMM;
        w_nextState = ST_I_WB;
      end
      ST_I_WB: begin
        RegWrite    = 1'b1;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = ALUB_REGB;
        ALUOp       = ALUOP_BRANCH;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        BranchNE    = r_branchNe;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_JUMP: begin
        PCWrite     = 1'b1;
        PCSource    = PCSRC_JUMP;
        w_retire    = 1'b1;
        w_nextState = ST_FETCH;
      end
      ST_HALT: Halted = 1'b1;
      ST_TRAP: Trap = 1'b1;
      default: w_nextState = ST_RST;
    endcase
  end

endmodule
